// File: rtl/construtor_caminho.sv
// Path builder: follows the predecessor chain from destination back to source,
// storing each visited node in a local buffer that the host reads afterwards.
module construtor_caminho #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_PATH   = 64,
    parameter int LEN_WIDTH  = $clog2(MAX_PATH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iniciar_in,
    input  logic                  construir_caminho_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  pred_rd_en_out,
    output logic [ADDR_WIDTH-1:0] pred_addr_out,
    input  logic [ADDR_WIDTH-1:0] pred_dado_in,
    input  logic                  pred_valido_in,
    output logic                  caminho_pronto_out,
    output logic                  sem_caminho_out,
    output logic [LEN_WIDTH-1:0]  comprimento_out,
    input  logic [LEN_WIDTH-1:0]  caminho_rd_addr_in,
    output logic [ADDR_WIDTH-1:0] caminho_rd_data_out
);

    localparam int IDX_W = $clog2(MAX_PATH);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PATH);

    typedef enum logic [2:0] {
        IDLE,
        GRAVAR,
        LER,
        ESPERA,
        PRONTO
    } estado_t;

    estado_t                estado_q;
    logic [ADDR_WIDTH-1:0]  atual_q;
    logic [LEN_WIDTH-1:0]   comprimento_q;
    logic [LEN_WIDTH-1:0]   comprimento_d;
    logic                   sem_caminho_q;
    logic [ADDR_WIDTH-1:0]  rd_data_q;
    logic                   grava;
    logic                   em_percurso;
    logic [ADDR_WIDTH-1:0]  buffer_q [MAX_PATH];

    assign comprimento_d = comprimento_q + 1'b1;
    assign em_percurso   = (estado_q == GRAVAR) || (estado_q == LER) || (estado_q == ESPERA);
    // Writes are suppressed on the cycle a clear or abort wins priority.
    assign grava = (estado_q == GRAVAR) && !iniciar_in && construir_caminho_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= IDLE;
            atual_q       <= '0;
            comprimento_q <= '0;
            sem_caminho_q <= 1'b0;
        end else if (iniciar_in) begin
            estado_q      <= IDLE;
            comprimento_q <= '0;
            sem_caminho_q <= 1'b0;
        end else if (!construir_caminho_in && em_percurso) begin
            estado_q      <= IDLE;
            comprimento_q <= '0;
        end else begin
            unique case (estado_q)
                IDLE: begin
                    if (construir_caminho_in) begin
                        atual_q       <= destino_in;
                        comprimento_q <= '0;
                        sem_caminho_q <= 1'b0;
                        estado_q      <= GRAVAR;
                    end
                end
                GRAVAR: begin
                    comprimento_q <= comprimento_d;
                    if (atual_q == fonte_in) begin
                        estado_q <= PRONTO;
                    end else if (comprimento_d == MAX_LEN) begin
                        // Buffer full without reaching the source: overflow or a cycle.
                        sem_caminho_q <= 1'b1;
                        estado_q      <= PRONTO;
                    end else begin
                        estado_q <= LER;
                    end
                end
                LER: begin
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    if (!pred_valido_in) begin
                        sem_caminho_q <= 1'b1;
                        estado_q      <= PRONTO;
                    end else begin
                        atual_q  <= pred_dado_in;
                        estado_q <= GRAVAR;
                    end
                end
                PRONTO: begin
                    if (!construir_caminho_in) begin
                        estado_q <= IDLE;
                    end
                end
                default: begin
                    estado_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grava) begin
            buffer_q[comprimento_q[IDX_W-1:0]] <= atual_q;
        end
    end

    // Out-of-range indices keep the previous read value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (caminho_rd_addr_in < MAX_LEN) begin
            rd_data_q <= buffer_q[caminho_rd_addr_in[IDX_W-1:0]];
        end
    end

    assign pred_rd_en_out      = (estado_q == LER);
    assign pred_addr_out       = (estado_q == LER) ? atual_q : '0;
    assign caminho_pronto_out  = (estado_q == PRONTO);
    assign sem_caminho_out     = sem_caminho_q;
    assign comprimento_out     = comprimento_q;
    assign caminho_rd_data_out = rd_data_q;

endmodule
